axon_delay_queue: RTL



---
 rtl/axon_delay_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axon_delay_queue.sv
`default_nettype none
// ============================================================================
// Module   : axon_delay_queue
// Brief    : Multi-slot countdown queue; releases each soma spike after its delay.
// Revision : 1.0
// ============================================================================
module axon_delay_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       kill,
    input  logic [DW-1:0]              spike_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DW-1:0]              out_delay,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       full,
    output logic [7:0]                 drop_cnt,
    output logic                       drop_pulse
);

    localparam int c_IW = $clog2(DEPTH);
    localparam int c_OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_valid;
    logic [DW-1:0]    r_cnt [DEPTH];
    logic [DW-1:0]    r_dly [DEPTH];

    logic [DEPTH-1:0] w_due;
    logic             w_any_free;
    logic [c_IW-1:0]  w_free_idx;
    logic [c_IW-1:0]  w_sel_idx;
    logic             w_spike;
    logic             w_alloc;
    logic             w_drop;
    logic             w_accept;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [c_OW-1:0]  w_occ_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_due
            assign w_due[gi] = r_valid[gi] && (r_cnt[gi] == '0);
        end
    endgenerate

    // Descending scan so the lowest index is the one left standing.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_sel_idx  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_any_free = 1'b1;
                w_free_idx = c_IW'(i);
            end
            if (w_due[i]) begin
                w_sel_idx = c_IW'(i);
            end
        end
    end

    assign out_valid = |w_due;
    assign out_delay = out_valid ? r_dly[w_sel_idx] : '0;

    assign w_spike  = (spike_in != '0);
    assign w_accept = out_valid && out_ready;
    assign w_alloc  = w_spike && w_any_free && !kill;
    assign w_drop   = w_spike && !w_any_free && !kill;

    // Post-edge valid mask, used only for the registered status outputs.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_accept) w_valid_nxt[w_sel_idx] = 1'b0;
        if (w_alloc)  w_valid_nxt[w_free_idx] = 1'b1;
        if (kill)     w_valid_nxt = '0;
        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_nxt = w_occ_nxt + c_OW'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= '0;
                r_dly[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill) begin
                    r_valid[i] <= 1'b0;
                    r_cnt[i]   <= '0;
                    r_dly[i]   <= '0;
                end else if (w_alloc && (w_free_idx == c_IW'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_cnt[i]   <= spike_in;
                    r_dly[i]   <= spike_in;
                end else if (w_accept && (w_sel_idx == c_IW'(i))) begin
                    r_valid[i] <= 1'b0;
                    r_dly[i]   <= '0;
                end else if (r_valid[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy  <= '0;
            full       <= 1'b0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            occupancy  <= w_occ_nxt;
            full       <= &w_valid_nxt;
            drop_pulse <= w_drop;
            if (w_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
